code_patch_engine: RTL and testbench

CODE_PATCH_ENGINE -- requirements
Module: code_patch_engine

---
 rtl/code_patch_engine.sv | 149 ++++++++++++++
 tb/tb_code_patch_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/code_patch_engine.sv
// Fetch-path patch engine: replaces fetched data with a table entry whose address matches.
// The table can be frozen by a lock that only reset releases.
//
// state       | meaning
// UNLOCKED    | table writable, lock request accepted
// LOCKED      | table frozen, every write is rejected with cfg_err_o
module code_patch_engine #(
   parameter  int ADDR_W    = 13,
   parameter  int DATA_W    = 22,
   parameter  int NUM_PATCH = 3,
   parameter  int CNT_W     = 8,
   localparam int IDX_W     = (NUM_PATCH > 1) ? $clog2(NUM_PATCH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cfg_pat_gen_i,
   input  logic              cfg_we_i,
   input  logic [IDX_W-1:0]  cfg_idx_i,
   input  logic [ADDR_W-1:0] cfg_addr_i,
   input  logic [DATA_W-1:0] cfg_data_i,
   input  logic              cfg_valid_i,
   input  logic              cfg_lock_i,
   input  logic              si_read_i,
   input  logic [ADDR_W-1:0] si_addr_i,
   input  logic [DATA_W-1:0] si_data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              data_vld_o,
   output logic              nopg_o,
   output logic [IDX_W-1:0]  hit_idx_o,
   output logic [CNT_W-1:0]  hit_cnt_o,
   output logic              locked_o,
   output logic              cfg_err_o
);

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic              valid_q [NUM_PATCH];
   logic              valid_d [NUM_PATCH];
   logic [ADDR_W-1:0] addr_q  [NUM_PATCH];
   logic [ADDR_W-1:0] addr_d  [NUM_PATCH];
   logic [DATA_W-1:0] pdata_q [NUM_PATCH];
   logic [DATA_W-1:0] pdata_d [NUM_PATCH];

   logic [DATA_W-1:0] data_q, data_d;
   logic              vld_q, vld_d;
   logic              nopg_q, nopg_d;
   logic [IDX_W-1:0]  hit_idx_q, hit_idx_d;
   logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
   logic              err_q, err_d;

   logic              hit;
   logic [IDX_W-1:0]  hit_idx;
   logic [DATA_W-1:0] hit_data;
   logic              idx_ok;
   logic              wr_en;

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      addr_d    = addr_q;
      pdata_d   = pdata_q;
      data_d    = data_q;
      vld_d     = 1'b0;
      nopg_d    = nopg_q;
      hit_idx_d = hit_idx_q;
      hit_cnt_d = hit_cnt_q;
      hit       = 1'b0;
      hit_idx   = '0;
      hit_data  = '0;

      // Descending scan so the lowest matching index is the one left standing.
      for (int i = NUM_PATCH - 1; i >= 0; i--) begin
         if (valid_q[i] && (addr_q[i] == si_addr_i)) begin
            hit      = 1'b1;
            hit_idx  = IDX_W'(i);
            hit_data = pdata_q[i];
         end
      end
      hit = hit & cfg_pat_gen_i & si_read_i;

      if (si_read_i) begin
         vld_d     = 1'b1;
         data_d    = hit ? hit_data : si_data_i;
         nopg_d    = ~hit;
         hit_idx_d = hit ? hit_idx : '0;
      end
      if (hit && (hit_cnt_q != {CNT_W{1'b1}})) begin
         hit_cnt_d = hit_cnt_q + 1'b1;
      end

      idx_ok = ({1'b0, cfg_idx_i} < (IDX_W + 1)'(NUM_PATCH));
      wr_en  = cfg_we_i && (state_q == ST_UNLOCKED) && idx_ok;
      err_d  = cfg_we_i && !wr_en;

      // Table update lands after the fetch lookup above, so fetches see pre-write contents.
      for (int i = 0; i < NUM_PATCH; i++) begin
         if (wr_en && (cfg_idx_i == IDX_W'(i))) begin
            valid_d[i] = cfg_valid_i;
            addr_d[i]  = cfg_addr_i;
            pdata_d[i] = cfg_data_i;
         end
      end

      if ((state_q == ST_UNLOCKED) && cfg_lock_i) begin
         state_d = ST_LOCKED;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_UNLOCKED;
         data_q    <= '0;
         vld_q     <= 1'b0;
         nopg_q    <= 1'b1;
         hit_idx_q <= '0;
         hit_cnt_q <= '0;
         err_q     <= 1'b0;
         for (int i = 0; i < NUM_PATCH; i++) begin
            valid_q[i] <= 1'b0;
            addr_q[i]  <= '0;
            pdata_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         vld_q     <= vld_d;
         nopg_q    <= nopg_d;
         hit_idx_q <= hit_idx_d;
         hit_cnt_q <= hit_cnt_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
         addr_q    <= addr_d;
         pdata_q   <= pdata_d;
      end
   end

   assign data_o     = data_q;
   assign data_vld_o = vld_q;
   assign nopg_o     = nopg_q;
   assign hit_idx_o  = hit_idx_q;
   assign hit_cnt_o  = hit_cnt_q;
   assign locked_o   = (state_q == ST_LOCKED);
   assign cfg_err_o  = err_q;

endmodule

// File: tb/tb_code_patch_engine.sv
// Bench for code_patch_engine: a table-level reference model checked every cycle,
// plus literal expectations for the headline scenarios. A second instance uses a 2-bit counter.
module tb_code_patch_engine;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 22;
   localparam int NP     = 3;
   localparam int IDX_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              pat_gen, we, cvalid, lock, rd;
   logic [IDX_W-1:0]  cidx;
   logic [ADDR_W-1:0] caddr, saddr;
   logic [DATA_W-1:0] cdata, sdata;

   logic [DATA_W-1:0] data_o, data2_o;
   logic              vld_o, vld2_o, nopg_o, nopg2_o, locked_o, locked2_o, err_o, err2_o;
   logic [IDX_W-1:0]  idx_o, idx2_o;
   logic [7:0]        cnt_o;
   logic [1:0]        cnt2_o;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   code_patch_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_PATCH(NP), .CNT_W(8)) dut (
      .clk_i(clk), .rst_i(rst), .cfg_pat_gen_i(pat_gen), .cfg_we_i(we), .cfg_idx_i(cidx),
      .cfg_addr_i(caddr), .cfg_data_i(cdata), .cfg_valid_i(cvalid), .cfg_lock_i(lock),
      .si_read_i(rd), .si_addr_i(saddr), .si_data_i(sdata),
      .data_o(data_o), .data_vld_o(vld_o), .nopg_o(nopg_o), .hit_idx_o(idx_o),
      .hit_cnt_o(cnt_o), .locked_o(locked_o), .cfg_err_o(err_o));

   code_patch_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_PATCH(NP), .CNT_W(2)) dut2 (
      .clk_i(clk), .rst_i(rst), .cfg_pat_gen_i(pat_gen), .cfg_we_i(we), .cfg_idx_i(cidx),
      .cfg_addr_i(caddr), .cfg_data_i(cdata), .cfg_valid_i(cvalid), .cfg_lock_i(lock),
      .si_read_i(rd), .si_addr_i(saddr), .si_data_i(sdata),
      .data_o(data2_o), .data_vld_o(vld2_o), .nopg_o(nopg2_o), .hit_idx_o(idx2_o),
      .hit_cnt_o(cnt2_o), .locked_o(locked2_o), .cfg_err_o(err2_o));

   // Reference model: the patch table as plain arrays plus the expected output registers.
   bit        m_valid [NP];
   int        m_addr  [NP];
   int        m_data  [NP];
   bit        m_locked;
   int        e_data, e_idx, e_cnt8, e_cnt2;
   bit        e_vld, e_nopg, e_err;

   always @(posedge clk) begin
      int win;
      if (rst) begin
         for (int i = 0; i < NP; i++) begin
            m_valid[i] = 0; m_addr[i] = 0; m_data[i] = 0;
         end
         m_locked = 0; e_data = 0; e_idx = 0; e_cnt8 = 0; e_cnt2 = 0;
         e_vld = 0; e_nopg = 1; e_err = 0;
      end else begin
         win = -1;
         if (pat_gen && rd)
            for (int i = 0; i < NP; i++)
               if (win < 0 && m_valid[i] && m_addr[i] == int'(saddr)) win = i;
         e_vld = rd;
         if (rd) begin
            e_nopg = (win < 0);
            e_data = (win < 0) ? int'(sdata) : m_data[win];
            e_idx  = (win < 0) ? 0 : win;
         end
         if (win >= 0) begin
            e_cnt8 = (e_cnt8 < 255) ? e_cnt8 + 1 : 255;
            e_cnt2 = (e_cnt2 < 3) ? e_cnt2 + 1 : 3;
         end
         e_err = we && (m_locked || int'(cidx) >= NP);
         if (we && !e_err) begin
            m_valid[cidx] = cvalid; m_addr[cidx] = int'(caddr); m_data[cidx] = int'(cdata);
         end
         if (lock) m_locked = 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("vld",     32'(vld_o),    32'(e_vld));
         chk("data",    32'(data_o),   e_data);
         chk("nopg",    32'(nopg_o),   32'(e_nopg));
         chk("hit_idx", 32'(idx_o),    e_idx);
         chk("cnt8",    32'(cnt_o),    e_cnt8);
         chk("locked",  32'(locked_o), 32'(m_locked));
         chk("err",     32'(err_o),    32'(e_err));
         chk("cnt2",    32'(cnt2_o),   e_cnt2);
         chk("data2",   32'(data2_o),  e_data);
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      we = 0; lock = 0; rd = 0; cvalid = 0;
   endtask

   task automatic wr(input int idx, input int a, input int d, input bit v);
      we = 1; cidx = IDX_W'(idx); caddr = ADDR_W'(a); cdata = DATA_W'(d); cvalid = v;
   endtask

   task automatic fetch(input int a, input int d);
      rd = 1; saddr = ADDR_W'(a); sdata = DATA_W'(d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      rst = 1; pat_gen = 0; idle(); cidx = 0; caddr = 0; cdata = 0; saddr = 0; sdata = 0;
      cyc(); cyc();
      chk_en = 1;
      chk("rst_data", 32'(data_o), 0);
      chk("rst_nopg", 32'(nopg_o), 1);
      chk("rst_lock", 32'(locked_o), 0);

      // Single entry hit
      rst = 0; pat_gen = 1;
      wr(1, 'h0A5, 'h155555, 1); cyc();
      idle(); fetch('h0A5, 'h3FFFFF); cyc();
      chk("hit_data", 32'(data_o), 'h155555);
      chk("hit_nopg", 32'(nopg_o), 0);
      chk("hit_idx1", 32'(idx_o), 1);
      chk("hit_cnt1", 32'(cnt_o), 1);
      idle(); cyc();
      chk("hold_vld", 32'(vld_o), 0);
      chk("hold_data", 32'(data_o), 'h155555);

      // Lowest index wins
      wr(0, 'h010, 'h1, 1); cyc();
      wr(2, 'h010, 'h2, 1); cyc();
      idle(); fetch('h010, 'h0); cyc();
      chk("prio_data", 32'(data_o), 'h1);
      chk("prio_idx", 32'(idx_o), 0);

      // Out-of-range index rejected; table untouched
      idle(); wr(3, 'h010, 'h3AAAAA, 1); cyc();
      chk("idx_err", 32'(err_o), 1);
      idle(); fetch('h010, 'h0); cyc();
      chk("idx_err_clr", 32'(err_o), 0);
      chk("idx_keep", 32'(data_o), 'h1);
      pat_gen = 0; fetch('h010, 'h2AAAAA); cyc();
      chk("pg_off_nopg", 32'(nopg_o), 1);
      chk("pg_off_data", 32'(data_o), 'h2AAAAA);
      pat_gen = 1;

      // Write-through fetch sees pre-write table
      idle(); wr(0, 'h010, 'h1, 0); cyc();
      wr(0, 'h020, 'h123, 1); fetch('h020, 'h777); cyc();
      chk("wt_miss", 32'(data_o), 'h777);
      we = 0; fetch('h020, 'h777); cyc();
      chk("wt_hit", 32'(data_o), 'h123);

      // Mixed fetch sweep under model checking
      for (int k = 0; k < 12; k++) begin
         idle();
         case (k % 4)
            0: fetch('h020, k);
            1: fetch('h0A5, k);
            2: fetch('h010, k);
            default: ;
         endcase
         if (k == 6) pat_gen = 0;
         if (k == 9) pat_gen = 1;
         cyc();
      end

      // Counter saturation on the 2-bit instance
      idle(); rst = 1; cyc(); rst = 0;
      wr(1, 'h055, 'h0AB, 1); cyc();
      idle();
      for (int k = 0; k < 5; k++) begin
         fetch('h055, 0); cyc();
         chk("sat_cnt2", 32'(cnt2_o), (k < 3) ? k + 1 : 3);
      end

      // Lock with simultaneous write, then rejected write, then reset
      idle(); wr(0, 'h066, 'h111, 1); lock = 1; cyc();
      chk("lock_set", 32'(locked_o), 1);
      chk("lock_wr_ok", 32'(err_o), 0);
      lock = 0; wr(0, 'h066, 'h222, 1); cyc();
      chk("lock_err", 32'(err_o), 1);
      idle(); fetch('h066, 0); cyc();
      chk("lock_err_pulse", 32'(err_o), 0);
      chk("lock_keep", 32'(data_o), 'h111);
      fetch('h066, 'h5); rst = 1; cyc();
      chk("rst_vld", 32'(vld_o), 0);
      chk("rst_unlock", 32'(locked_o), 0);
      rst = 0; fetch('h066, 'h3); cyc();
      chk("rst_cleared", 32'(nopg_o), 1);
      chk("rst_cleared_d", 32'(data_o), 'h3);
      idle(); cyc();

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
